// File: rtl/piho_epoch_sched.sv
// Epoch scheduler for a ring of piho lattice units: seeds and resets the units, waits for
// completion, exchanges ring boundaries and accumulates post-warmup x2sum into one total.
module piho_epoch_sched #(
  parameter int unsigned NUNITS = 4,
  parameter int unsigned EPW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EPW-1:0]       num_epochs,
  input  logic [EPW-1:0]       warmup_epochs,
  input  logic [15:0]          seed_base,
  input  logic [31:0]          timeout_cycles,
  output logic [NUNITS-1:0]    unit_rst,
  output logic [16*NUNITS-1:0] unit_seed1,
  output logic [14*NUNITS-1:0] unit_seed2,
  output logic [32*NUNITS-1:0] unit_before,
  output logic [32*NUNITS-1:0] unit_after,
  input  logic [NUNITS-1:0]    unit_finish,
  input  logic [32*NUNITS-1:0] unit_first,
  input  logic [32*NUNITS-1:0] unit_last,
  input  logic [64*NUNITS-1:0] unit_x2sum,
  output logic                 busy,
  output logic [EPW-1:0]       epoch,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [63:0]          result_x2sum,
  output logic                 error
);

  localparam int unsigned IW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

  typedef enum logic [3:0] {IDLE, SEED, PULSE, RUN, LATCH, ACC, NEXT, OUT, ERR} state_t;

  state_t                state, state_nx;
  logic [EPW-1:0]        cfg_num, cfg_warm, epoch_q;
  logic [15:0]           cfg_seed;
  logic [31:0]           cfg_tmo, run_cnt;
  logic [IW-1:0]         acc_idx;
  logic [63:0]           acc;
  logic [63:0]           xbuf [NUNITS];
  logic [16*NUNITS-1:0]  seed1_q;
  logic [14*NUNITS-1:0]  seed2_q;
  logic [32*NUNITS-1:0]  before_q, after_q;
  logic                  error_q;
  logic                  all_fin, tmo_hit, last_epoch, acc_en;

  function automatic logic [29:0] mk_seeds(input logic [15:0] base, input logic [7:0] ep,
                                           input logic [7:0] idx);
    logic [15:0] s;
    logic [13:0] t;
    logic [15:0] s1;
    logic [13:0] s2;
    s  = base ^ {ep, idx};
    t  = s[13:0] ^ {s[15:14], s[15:4]};
    s1 = (s == 16'h0000) ? 16'h0001 : s;
    s2 = (t == 14'h0000) ? 14'h0001 : t;
    return {s1, s2};
  endfunction

  // The first RUN cycle is masked so a finish level left over from the previous epoch
  // cannot be mistaken for completion.
  assign all_fin    = (&unit_finish) && (run_cnt != 32'd0);
  assign tmo_hit    = (cfg_tmo != 32'd0) && (run_cnt >= cfg_tmo - 32'd1);
  assign last_epoch = ((EPW+1)'(epoch_q) + (EPW+1)'(1)) == (EPW+1)'(cfg_num);
  assign acc_en     = (epoch_q >= cfg_warm);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SEED;
      SEED:    state_nx = PULSE;
      PULSE:   state_nx = RUN;
      RUN: begin
        if (all_fin)      state_nx = LATCH;
        else if (tmo_hit) state_nx = ERR;
      end
      LATCH:   state_nx = ACC;
      ACC:     if (acc_idx == IW'(NUNITS - 1)) state_nx = NEXT;
      NEXT:    state_nx = last_epoch ? OUT : SEED;
      OUT:     if (result_ready) state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cfg_num  <= '0;
      cfg_warm <= '0;
      cfg_seed <= '0;
      cfg_tmo  <= '0;
      epoch_q  <= '0;
      run_cnt  <= '0;
      acc_idx  <= '0;
      acc      <= '0;
      seed1_q  <= '0;
      seed2_q  <= '0;
      before_q <= '0;
      after_q  <= '0;
      error_q  <= 1'b0;
      for (int unsigned i = 0; i < NUNITS; i++) xbuf[i] <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == ERR) error_q <= 1'b1;
      case (state)
        IDLE: if (start) begin
          cfg_num  <= (num_epochs == '0) ? EPW'(1) : num_epochs;
          cfg_warm <= warmup_epochs;
          cfg_seed <= seed_base;
          cfg_tmo  <= timeout_cycles;
          acc      <= '0;
          epoch_q  <= '0;
          error_q  <= 1'b0;
          before_q <= '0;
          after_q  <= '0;
        end
        SEED: begin
          for (int unsigned i = 0; i < NUNITS; i++)
            {seed1_q[16*i +: 16], seed2_q[14*i +: 14]} <= mk_seeds(cfg_seed, 8'(epoch_q), 8'(i));
        end
        PULSE: run_cnt <= '0;
        RUN:   run_cnt <= run_cnt + 32'd1;
        LATCH: begin
          acc_idx <= '0;
          for (int unsigned i = 0; i < NUNITS; i++) begin
            before_q[32*i +: 32] <= unit_last[32*((i + NUNITS - 1) % NUNITS) +: 32];
            after_q[32*i +: 32]  <= unit_first[32*((i + 1) % NUNITS) +: 32];
            xbuf[i]              <= unit_x2sum[64*i +: 64];
          end
        end
        ACC: begin
          if (acc_en) acc <= acc + xbuf[acc_idx];
          acc_idx <= acc_idx + IW'(1);
        end
        NEXT: if (!last_epoch) epoch_q <= epoch_q + EPW'(1);
        default: ;
      endcase
    end
  end

  assign unit_rst     = (rst || state == PULSE) ? '1 : '0;
  assign unit_seed1   = seed1_q;
  assign unit_seed2   = seed2_q;
  assign unit_before  = before_q;
  assign unit_after   = after_q;
  assign busy         = (state != IDLE);
  assign epoch        = epoch_q;
  assign result_valid = (state == OUT);
  assign result_x2sum = acc;
  assign error        = error_q;

endmodule

// File: tb/tb_piho_epoch_sched.sv
// Directed bench for piho_epoch_sched with behavioural units that finish 20 cycles after reset.
module tb_piho_epoch_sched;
  localparam int N   = 4;
  localparam int EPW = 8;

  logic           clk = 1'b0;
  logic           rst, start, result_ready;
  logic [EPW-1:0] num_epochs, warmup_epochs, epoch;
  logic [15:0]    seed_base;
  logic [31:0]    timeout_cycles;
  logic [N-1:0]   unit_rst, unit_finish;
  logic [16*N-1:0] unit_seed1;
  logic [14*N-1:0] unit_seed2;
  logic [32*N-1:0] unit_before, unit_after, unit_first, unit_last;
  logic [64*N-1:0] unit_x2sum;
  logic           busy, result_valid, error;
  logic [63:0]    result_x2sum;

  always #5 clk = ~clk;

  piho_epoch_sched #(.NUNITS(N), .EPW(EPW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_epochs(num_epochs),
    .warmup_epochs(warmup_epochs), .seed_base(seed_base), .timeout_cycles(timeout_cycles),
    .unit_rst(unit_rst), .unit_seed1(unit_seed1), .unit_seed2(unit_seed2),
    .unit_before(unit_before), .unit_after(unit_after), .unit_finish(unit_finish),
    .unit_first(unit_first), .unit_last(unit_last), .unit_x2sum(unit_x2sum),
    .busy(busy), .epoch(epoch), .result_valid(result_valid), .result_ready(result_ready),
    .result_x2sum(result_x2sum), .error(error));

  // Behavioural units
  logic [63:0]  mx2 [N];
  logic [N-1:0] hang;
  logic [N-1:0] fin;
  int           ucnt [N];

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (unit_rst[i]) begin
        ucnt[i] <= 0;
        fin[i]  <= 1'b0;
      end else if (!fin[i] && !hang[i]) begin
        if (ucnt[i] == 19) fin[i] <= 1'b1;
        ucnt[i] <= ucnt[i] + 1;
      end
  assign unit_finish = fin;

  for (genvar g = 0; g < N; g++) begin : g_unit
    assign unit_first[32*g +: 32] = 32'(16*g + 1);
    assign unit_last[32*g +: 32]  = 32'(16*g + 2);
    assign unit_x2sum[64*g +: 64] = mx2[g];
  end

  // Pulse / valid monitors, read as deltas by the test
  int   pulses = 0, long_pulses = 0, split_rst = 0, valid_cycles = 0;
  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    prev_rst <= unit_rst[0];
    if (!rst) begin
      if (unit_rst[0] && !prev_rst) pulses <= pulses + 1;
      if (unit_rst[0] && prev_rst)  long_pulses <= long_pulses + 1;
      if (unit_rst != '0 && unit_rst != '1) split_rst <= split_rst + 1;
    end
    if (result_valid) valid_cycles <= valid_cycles + 1;
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] ne, input logic [7:0] we, input logic [15:0] sb,
                          input logic [31:0] tmo);
    num_epochs = ne; warmup_epochs = we; seed_base = sb; timeout_cycles = tmo;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("result_valid_reached", 64'(result_valid), 64'd1);
  endtask

  task automatic finish_run(input string name, input logic [63:0] exp);
    int cyc;
    wait_valid(400, cyc);
    chk(name, result_x2sum, exp);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [15:0] base;
    int          unit;
    logic [15:0] s1;
    logic [13:0] s2;
  } seed_vec_t;

  seed_vec_t vecs [9];

  initial begin
    int cyc, p0, l0, v0, sp0;
    vecs[0] = '{16'h0000, 0, 16'h0001, 14'h0001};
    vecs[1] = '{16'h0000, 1, 16'h0001, 14'h0001};
    vecs[2] = '{16'h0000, 3, 16'h0003, 14'h0003};
    vecs[3] = '{16'hABCD, 0, 16'hABCD, 14'h0171};
    vecs[4] = '{16'hABCD, 2, 16'hABCF, 14'h0173};
    vecs[5] = '{16'h0003, 3, 16'h0001, 14'h0001};
    vecs[6] = '{16'h0010, 0, 16'h0010, 14'h0011};
    vecs[7] = '{16'hFFFF, 1, 16'hFFFE, 14'h0001};
    vecs[8] = '{16'hFFFF, 0, 16'hFFFF, 14'h0001};

    rst = 1'b1; start = 1'b0; result_ready = 1'b0; hang = '0;
    num_epochs = '0; warmup_epochs = '0; seed_base = '0; timeout_cycles = '0;
    for (int i = 0; i < N; i++) mx2[i] = 64'(i + 1);
    tick(); tick();
    chk("rst_unit_rst", 64'(unit_rst), 64'hF);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(result_valid), 64'd0);
    chk("rst_result", result_x2sum, 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_epoch", 64'(epoch), 64'd0);
    rst = 1'b0;
    tick();
    chk("unit_rst_released", 64'(unit_rst), 64'd0);

    // Basic run: latency from start and sum of i+1
    do_start(8'd1, 8'd0, 16'h1234, 32'd0);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_valid(200, cyc);
    chk("valid_latency", 64'(cyc), 64'd29);
    chk("sum_basic", result_x2sum, 64'd10);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("busy_after_hs", 64'(busy), 64'd0);
    chk("valid_after_hs", 64'(result_valid), 64'd0);

    // Seed table: every vector starts a 1-epoch run and inspects the PULSE cycle
    foreach (vecs[k]) begin
      do_start(8'd1, 8'd0, vecs[k].base, 32'd0);
      tick();
      chk($sformatf("pulse_at_start_plus2_%0d", k), 64'(unit_rst), 64'hF);
      chk($sformatf("seed1_v%0d", k), 64'(unit_seed1[16*vecs[k].unit +: 16]), 64'(vecs[k].s1));
      chk($sformatf("seed2_v%0d", k), 64'(unit_seed2[14*vecs[k].unit +: 14]), 64'(vecs[k].s2));
      finish_run($sformatf("seed_run_sum_%0d", k), 64'd10);
    end

    // Warmup: 3 epochs, first excluded, 100 per unit
    for (int i = 0; i < N; i++) mx2[i] = 64'd100;
    p0 = pulses; l0 = long_pulses; sp0 = split_rst;
    do_start(8'd3, 8'd1, 16'h0777, 32'd0);
    finish_run("sum_warmup", 64'd800);
    chk("pulse_count", 64'(pulses - p0), 64'd3);
    chk("pulse_width", 64'(long_pulses - l0), 64'd0);
    chk("pulse_all_units", 64'(split_rst - sp0), 64'd0);

    // Boundary exchange and epoch-1 seeds
    for (int i = 0; i < N; i++) mx2[i] = 64'(i + 1);
    do_start(8'd2, 8'd0, 16'h0000, 32'd0);
    tick(); tick();
    chk("before0_epoch0", 64'(unit_before[31:0]), 64'd0);
    cyc = 0;
    while (epoch !== 8'd1 && cyc < 100) begin tick(); cyc++; end
    chk("epoch_advanced", 64'(epoch), 64'd1);
    tick();
    chk("before0", 64'(unit_before[0*32 +: 32]), 64'd50);
    chk("after3", 64'(unit_after[3*32 +: 32]), 64'd1);
    chk("before2", 64'(unit_before[2*32 +: 32]), 64'd18);
    chk("after1", 64'(unit_after[1*32 +: 32]), 64'd33);
    chk("seed1_e1_u2", 64'(unit_seed1[2*16 +: 16]), 64'h0102);
    chk("seed2_e1_u2", 64'(unit_seed2[2*14 +: 14]), 64'h0112);
    finish_run("sum_two_epochs", 64'd20);

    // Timeout with unit 2 stuck
    hang[2] = 1'b1;
    v0 = valid_cycles;
    do_start(8'd1, 8'd0, 16'h00AA, 32'd50);
    cyc = 0;
    while (error !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    chk("timeout_latency", 64'(cyc), 64'd52);
    tick();
    chk("err_to_idle", 64'(busy), 64'd0);
    chk("error_sticky", 64'(error), 64'd1);
    chk("err_unit_rst", 64'(unit_rst), 64'd0);
    repeat (3) tick();
    chk("no_valid_on_abort", 64'(valid_cycles - v0), 64'd0);
    hang[2] = 1'b0;
    do_start(8'd1, 8'd0, 16'h00AA, 32'd50);
    chk("error_cleared", 64'(error), 64'd0);
    finish_run("sum_after_error", 64'd10);

    // Warmup >= num_epochs, num_epochs==0, wraparound
    do_start(8'd2, 8'd5, 16'h1111, 32'd0);
    finish_run("sum_all_warmup", 64'd0);
    p0 = pulses;
    do_start(8'd0, 8'd0, 16'h2222, 32'd0);
    finish_run("sum_zero_epochs", 64'd10);
    chk("zero_epochs_pulses", 64'(pulses - p0), 64'd1);
    for (int i = 0; i < N; i++) mx2[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_start(8'd1, 8'd0, 16'h3333, 32'd0);
    finish_run("sum_wrap", 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < N; i++) mx2[i] = 64'(i + 1);

    // Reset during ACC
    do_start(8'd1, 8'd0, 16'h4444, 32'd0);
    repeat (25) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", result_x2sum, 64'd0);
    chk("midrst_seed1", unit_seed1, 64'd0);
    chk("midrst_before", unit_before[63:0], 64'd0);
    chk("midrst_after", unit_after[63:0], 64'd0);
    chk("midrst_unit_rst", 64'(unit_rst), 64'hF);
    chk("midrst_valid", 64'(result_valid), 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst_release", 64'(unit_rst), 64'd0);

    // Start while busy is ignored; result held while ready is low
    do_start(8'd2, 8'd0, 16'h5555, 32'd0);
    repeat (5) tick();
    num_epochs = 8'd5; seed_base = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(400, cyc);
    chk("busy_start_sum", result_x2sum, 64'd20);
    chk("busy_start_epoch", 64'(epoch), 64'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("hold_valid_%0d", k), 64'(result_valid), 64'd1);
      chk($sformatf("hold_result_%0d", k), result_x2sum, 64'd20);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("hold_hs_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/piho_epoch_sched.md
Name: piho_epoch_sched

Overview:
- Scheduler for a ring of NUNITS piho lattice units. Each unit simulates one segment of a periodic lattice.
- Runs the units in lock-step epochs. Each epoch: re-seed and pulse-reset all units, wait for every finish, exchange segment boundaries around the ring, then accumulate post-warmup x2sum.
- Returns one 64-bit total through a valid/ready readout.
- Sits between the host/config registers and the unit array.

Parameters:
NUNITS, 4, number of piho units in the ring (2..16)
EPW, 8, width of epoch counter and epoch config inputs

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle start request, accepted only in IDLE
num_epochs  in  EPW  total epochs to run, latched at start; 0 treated as 1
warmup_epochs  in  EPW  leading epochs excluded from accumulation, latched at start
seed_base  in  16  base seed, latched at start
timeout_cycles  in  32  max RUN cycles per epoch, latched at start; 0 disables
unit_rst  out  NUNITS  reset pulse to each unit
unit_seed1  out  16*NUNITS  seed1 per unit, slice i = [16i+15:16i]
unit_seed2  out  14*NUNITS  seed2 per unit
unit_before  out  32*NUNITS  left boundary value per unit
unit_after  out  32*NUNITS  right boundary value per unit
unit_finish  in  NUNITS  per-unit finish level, high until the unit is reset
unit_first  in  32*NUNITS  per-unit first lattice element
unit_last  in  32*NUNITS  per-unit last lattice element
unit_x2sum  in  64*NUNITS  per-unit x2sum
busy  out  1  high in any state except IDLE
epoch  out  EPW  current epoch index
result_valid  out  1  total available
result_ready  in  1  consumer accepts the total
result_x2sum  out  64  accumulated total
error  out  1  sticky timeout flag, cleared by the next accepted start or by rst

Behaviour:
- Reset values:
  - unit_rst all-ones while rst is high, then 0.
  - seeds, boundaries, epoch, result_x2sum, result_valid, error, busy all 0.
  - State goes to IDLE.
  - rst mid-operation aborts immediately and discards any partial accumulation.
- States: IDLE, SEED, PULSE, RUN, LATCH, ACC, NEXT, OUT, ERR.
- IDLE:
  - On start: latch the config inputs, clear the accumulator, epoch=0, error=0, all boundaries=0, go to SEED.
  - start in any other state is ignored.
- SEED (1 cycle), per unit i:
  - s = seed_base ^ {epoch[7:0], i[7:0]} (epoch zero-extended if EPW<8).
  - unit_seed1[i] = s, or 16'h0001 if s==0.
  - t = s[13:0] ^ {s[15:14], s[15:4]}; unit_seed2[i] = t, or 14'h0001 if t==0.
  - Seeds hold stable until the next SEED.
- PULSE (1 cycle):
  - unit_rst = all-ones; clear the RUN cycle counter.
  - The unit_rst rising edge occurs 2 cycles after the start cycle.
- RUN:
  - unit_rst=0. Wait until unit_finish is all-ones, sampled at least 2 cycles after PULSE so stale finish levels are masked; then go to LATCH.
  - If timeout_cycles!=0 and the counter reaches timeout_cycles: go to ERR.
- LATCH (1 cycle), for every i, modulo NUNITS:
  - unit_before[i] <= unit_last[i-1].
  - unit_after[i] <= unit_first[i+1].
  - Snapshot all unit_x2sum into an internal buffer.
  - The new boundaries take effect at the next epoch's PULSE.
- ACC (NUNITS cycles):
  - One 64-bit add per cycle, unit 0 first, only if epoch >= warmup_epochs.
  - Addition wraps modulo 2^64; no saturation.
- NEXT (1 cycle):
  - If epoch+1 == effective num_epochs: go to OUT.
  - Else epoch++ and go to SEED.
- OUT:
  - result_valid=1 and result_x2sum=accumulator, both held stable until result_ready.
  - A cycle with valid&ready completes the transfer; next cycle result_valid=0 and state IDLE.
  - result_ready while not valid is ignored.
- ERR (1 cycle): error=1, unit_rst held 0, go to IDLE. result_valid is never asserted for an aborted run.
- warmup_epochs >= num_epochs: the run completes normally with result 0.
- epoch output reads the index of the epoch in progress; it holds its last value in OUT/IDLE.

Test Plan:
- NUNITS=4, num_epochs=1, warmup=0, behavioural units finishing after 20 cycles with x2sum=i+1 -> result_valid after all finish+LATCH+4 ACC+NEXT; result_x2sum=10; busy falls the cycle after the handshake.
- num_epochs=3, warmup=1, unit x2sum=100 each epoch -> result 800; 3 unit_rst pulses, each exactly 1 cycle.
- Unit first=16*i+1, last=16*i+2 in epoch 0 -> during epoch 1: unit_before[0]=50, unit_after[3]=1, unit_before[2]=18, unit_after[1]=33.
- seed_base=16'h0000, epoch 0 -> unit_seed1[0]=16'h0001 (zero substitution), unit_seed1[1]=16'h0001, unit_seed2 nonzero for all units.
- Unit 2 never finishes, timeout_cycles=50 -> ERR reached 50 cycles into RUN; error=1, result_valid never 1; a following start clears error.
- rst asserted in ACC, and start pulsed while busy -> rst: all outputs return to reset values next cycle. start-while-busy: no state change, config not re-latched. result_ready held low 10 cycles in OUT -> result_x2sum stable throughout.
